sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ram.sv | 32 +++
 rtl/sync_fifo.sv | 150 +++++++++++++++
 tb/tb_sync_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the synchronous FIFO.
//   fifo_mode_e selects the read-side behaviour of sync_fifo:
//     FIFO_STD  - rd_data updates one cycle after an accepted read
//     FIFO_FWFT - head word is pre-loaded into an output register
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DATA_WIDTH x 2**ADDR_WIDTH storage, one write port and one
// synchronous read port on a single clock. Contents are not reset.
//   clk_i    clock
//   we_i     write enable, wdata_i stored at waddr_i
//   re_i     read enable, mem[raddr_i] captured into rdata_o
//   rdata_o  read data, holds its value while re_i is low
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered flags and two read modes.
//   clk           clock, rising edge
//   async_rst     asynchronous active-high reset
//   write/wr_data write request and word, accepted iff !full
//   read          read (STD) / pop (FWFT) request, accepted iff !empty
//   af_thresh     almost_full when count >= af_thresh
//   ae_thresh     almost_empty when count <= ae_thresh
//   rd_data       read word
//   full/empty    registered occupancy flags
//   almost_full/almost_empty  registered threshold flags
//   count         words held, 0..DEPTH (includes the FWFT output register)
//   overflow/underflow  one-cycle pulse after a rejected write/read
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 3,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  read,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, af_q, ae_q, ovf_q, unf_q;
  logic                  wr_acc, rd_acc, ram_re, storage_ne, empty_int;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_acc     = write && !full_q;
  assign rd_acc     = read && !empty_int;
  // words still in the RAM array (not yet moved into a read stage)
  assign storage_ne = (rd_ptr_q != wr_ptr_q);

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + ONE_C;
    else if (rd_acc && !wr_acc) count_d = count_q - ONE_C;
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ONE_C;
      if (ram_re) rd_ptr_q <= rd_ptr_q + ONE_C;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      af_q    <= (count_d >= af_thresh);
      ae_q    <= (count_d <= ae_thresh);
      ovf_q   <= write && full_q;
      unf_q   <= read && empty_int;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic empty_q, loaded_q;

    // storage_ne always holds when rd_acc does; the RAM read stays
    // gated by the pointers themselves
    assign ram_re    = rd_acc && storage_ne;
    assign empty_int = empty_q;
    // RAM read data is not reset, so mask it until the first real read
    assign rd_data   = loaded_q ? ram_rdata : '0;

    always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
        empty_q  <= 1'b1;
        loaded_q <= 1'b0;
      end else begin
        empty_q <= (count_d == '0);
        if (rd_acc) loaded_q <= 1'b1;
      end
    end
  end else begin : g_fwft
    // Two read stages follow the RAM array: the RAM read register (mid)
    // and the output register holding the head word. mid is refilled in
    // the same edge it hands its word to the output register, so a
    // sustained pop stream moves one word per cycle.
    logic                  out_valid_q, mid_valid_q, load_out;
    logic [DATA_WIDTH-1:0] out_q;

    assign load_out  = (!out_valid_q || rd_acc) && mid_valid_q;
    assign ram_re    = (!mid_valid_q || load_out) && storage_ne;
    assign empty_int = !out_valid_q;
    assign rd_data   = out_q;

    always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
        out_valid_q <= 1'b0;
        mid_valid_q <= 1'b0;
        out_q       <= '0;
      end else begin
        if (load_out) begin
          out_q       <= ram_rdata;
          out_valid_q <= 1'b1;
        end else if (rd_acc) begin
          out_valid_q <= 1'b0;
        end
        if (ram_re)        mid_valid_q <= 1'b1;
        else if (load_out) mid_valid_q <= 1'b0;
      end
    end
  end

  assign full         = full_q;
  assign empty        = empty_int;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [3:0] af_thresh = 4'd6;
  logic [3:0] ae_thresh = 4'd2;

  // index 0: FIFO_STD instance, index 1: FIFO_FWFT instance
  logic [7:0] rd_data_w [2];
  logic       full_w [2];
  logic       empty_w [2];
  logic       af_w [2];
  logic       ae_w [2];
  logic [3:0] count_w [2];
  logic       ovf_w [2];
  logic       unf_w [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .MODE(FIFO_STD)) u_std (
    .clk(clk), .async_rst(async_rst), .write(write), .wr_data(wr_data),
    .read(read), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .rd_data(rd_data_w[0]), .full(full_w[0]), .empty(empty_w[0]),
    .almost_full(af_w[0]), .almost_empty(ae_w[0]), .count(count_w[0]),
    .overflow(ovf_w[0]), .underflow(unf_w[0]));

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .async_rst(async_rst), .write(write), .wr_data(wr_data),
    .read(read), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .rd_data(rd_data_w[1]), .full(full_w[1]), .empty(empty_w[1]),
    .almost_full(af_w[1]), .almost_empty(ae_w[1]), .count(count_w[1]),
    .overflow(ovf_w[1]), .underflow(unf_w[1]));

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s mode=%0d actual=0x%0h required=0x%0h", nm, m, act, req);
    end
  endtask

  // Reference model: a queue of words with the edge number each was written.
  // STD: any held word is readable. FWFT: the head is visible once two edges
  // have passed since its write.
  typedef struct {
    logic [7:0] d;
    int         w;
  } ent_t;

  ent_t       mq [2][$];
  logic [7:0] exp_q [2][$];
  int         cyc = 0;
  int         exp_count [2];
  bit         exp_full [2], exp_empty [2], exp_af [2], exp_ae [2], exp_ovf [2], exp_unf [2];

  always @(posedge clk) begin
    bit   mfull, mempty, wacc, racc;
    ent_t e;
    cyc++;
    if (!async_rst) begin
      for (int m = 0; m < 2; m++) begin
        mfull = (mq[m].size() == 8);
        if (m == 0) mempty = (mq[m].size() == 0);
        else        mempty = (mq[m].size() == 0) || (cyc <= mq[m][0].w + 2);
        wacc = write && !mfull;
        racc = read && !mempty;
        if (racc) begin
          exp_q[m].push_back(mq[m][0].d);
          void'(mq[m].pop_front());
        end
        if (wacc) begin
          e.d = wr_data;
          e.w = cyc;
          mq[m].push_back(e);
        end
        exp_count[m] = mq[m].size();
        exp_full[m]  = (mq[m].size() == 8);
        if (m == 0) exp_empty[m] = (mq[m].size() == 0);
        else        exp_empty[m] = !((mq[m].size() > 0) && (cyc >= mq[m][0].w + 2));
        exp_af[m]  = (mq[m].size() >= int'(af_thresh));
        exp_ae[m]  = (mq[m].size() <= int'(ae_thresh));
        exp_ovf[m] = write && mfull;
        exp_unf[m] = read && mempty;
      end
    end
  end

  // Monitor: a read handshake (read && !empty) seen before an edge means a
  // word leaves the DUT on that edge; it is compared after the edge, once the
  // model has queued the expected word.
  bit         pend [2];
  logic [7:0] cap [2];

  always @(negedge clk) begin
    logic [7:0] ev, av;
    if (!async_rst) begin
      for (int m = 0; m < 2; m++) begin
        if (pend[m]) begin
          if (exp_q[m].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_read mode=%0d actual=0x%0h required=no_word", m, rd_data_w[m]);
          end else begin
            ev = exp_q[m].pop_front();
            av = (m == 0) ? rd_data_w[0] : cap[m];
            chk("sb_rd_data", m, av, ev);
          end
        end
        chk("count", m, count_w[m], exp_count[m]);
        chk("full", m, full_w[m], exp_full[m]);
        chk("empty", m, empty_w[m], exp_empty[m]);
        chk("almost_full", m, af_w[m], exp_af[m]);
        chk("almost_empty", m, ae_w[m], exp_ae[m]);
        chk("overflow", m, ovf_w[m], exp_ovf[m]);
        chk("underflow", m, unf_w[m], exp_unf[m]);
        pend[m] = read && !empty_w[m];
        cap[m]  = rd_data_w[m];
      end
    end
  end

  task automatic step(input bit w, input logic [7:0] d, input bit r);
    write   = w;
    wr_data = d;
    read    = r;
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic do_reset();
    write     = 1'b0;
    read      = 1'b0;
    async_rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_rd_data", m, rd_data_w[m], 0);
      chk("rst_full", m, full_w[m], 0);
      chk("rst_empty", m, empty_w[m], 1);
      chk("rst_almost_empty", m, ae_w[m], 1);
      chk("rst_almost_full", m, af_w[m], 0);
      chk("rst_count", m, count_w[m], 0);
      chk("rst_overflow", m, ovf_w[m], 0);
      chk("rst_underflow", m, unf_w[m], 0);
      mq[m].delete();
      exp_q[m].delete();
      pend[m]      = 1'b0;
      exp_count[m] = 0;
      exp_full[m]  = 1'b0;
      exp_empty[m] = 1'b1;
      exp_af[m]    = 1'b0;
      exp_ae[m]    = 1'b1;
      exp_ovf[m]   = 1'b0;
      exp_unf[m]   = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    async_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    do_reset();

    // fill to full, then one rejected write
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("fill_full", m, full_w[m], 1);
      chk("fill_count", m, count_w[m], 8);
      chk("fill_almost_full", m, af_w[m], 1);
    end
    step(1'b1, 8'hFF, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("ovf_pulse", m, ovf_w[m], 1);
      chk("ovf_count", m, count_w[m], 8);
    end
    step(1'b0, 8'h00, 1'b0);
    for (int m = 0; m < 2; m++) chk("ovf_clear", m, ovf_w[m], 0);

    // drain back to back
    for (int i = 1; i <= 8; i++) begin
      chk("fwft_head", 1, rd_data_w[1], i);
      step(1'b0, 8'h00, 1'b1);
      chk("std_rd_data", 0, rd_data_w[0], i);
    end
    for (int m = 0; m < 2; m++) chk("drain_empty", m, empty_w[m], 1);
    step(1'b0, 8'h00, 1'b1);
    for (int m = 0; m < 2; m++) chk("unf_pulse", m, unf_w[m], 1);
    chk("std_rd_hold", 0, rd_data_w[0], 8'h08);

    // single word into an empty FIFO
    step(1'b1, 8'hA5, 1'b0);
    chk("fwft_lat_empty0", 1, empty_w[1], 1);
    chk("fwft_lat_count", 1, count_w[1], 1);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_lat_empty1", 1, empty_w[1], 1);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_lat_empty2", 1, empty_w[1], 0);
    chk("fwft_lat_data", 1, rd_data_w[1], 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    for (int m = 0; m < 2; m++) chk("single_empty", m, empty_w[m], 1);
    chk("std_single_data", 0, rd_data_w[0], 8'hA5);

    // steady write+read at count 4, pointers wrap
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1);
      for (int m = 0; m < 2; m++) chk("steady_count", m, count_w[m], 4);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    for (int m = 0; m < 2; m++) chk("steady_drained", m, empty_w[m], 1);

    // randomized traffic with varying thresholds and load
    for (int s = 0; s < 6; s++) begin
      int wp, rp;
      af_thresh = 4'($urandom_range(8, 1));
      ae_thresh = 4'($urandom_range(7, 0));
      wp = 20 + 12 * s;
      rp = 90 - 12 * s;
      for (int i = 0; i < 250; i++)
        step(($urandom_range(99, 0) < wp), 8'($urandom), ($urandom_range(99, 0) < rp));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
    af_thresh = 4'd6;
    ae_thresh = 4'd2;

    // reset in the middle of a burst at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int m = 0; m < 2; m++) chk("pre_rst_count", m, count_w[m], 5);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1);
    do_reset();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_fwft_data", 1, rd_data_w[1], 8'h3C);
    chk("post_rst_fwft_empty", 1, empty_w[1], 0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_std_data", 0, rd_data_w[0], 8'h3C);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    for (int m = 0; m < 2; m++) chk("sb_leftover", m, exp_q[m].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
